// File: rtl/barrelshifter_pkg.sv
// Shared types for the pipelined barrel shifter.
// Operation codes 3'b101..3'b111 are not named here; they pass the operand through unchanged.
package barrelshifter_pkg;

  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROL = 3'b011,
    ROR = 3'b100
  } op_t;

endpackage

// File: rtl/barrelshifter_stage.sv
// One combinational barrel-shifter step: shift/rotate by SHIFT when en is set.
// Flag accumulation ports exist only when BARRELSHIFTER_FLAGS_EN is defined.
module barrelshifter_stage
  import barrelshifter_pkg::*;
#(
  parameter int D_SIZE = 32,
  parameter int SHIFT  = 1
) (
  input  op_t               op,
  input  logic              en,
  input  logic [D_SIZE-1:0] data,
`ifdef BARRELSHIFTER_FLAGS_EN
  input  logic              sign,
  input  logic              vf_acc,
  output logic              vf_next,
`endif
  output logic [D_SIZE-1:0] shifted
);

  always_comb begin
    shifted = data;
    if (en) begin
      case (op)
        SLL:     shifted = data << SHIFT;
        SRL:     shifted = data >> SHIFT;
        SRA:     shifted = D_SIZE'($signed(data) >>> SHIFT);
        ROL:     shifted = (data << SHIFT) | (data >> (D_SIZE - SHIFT));
        ROR:     shifted = (data >> SHIFT) | (data << (D_SIZE - SHIFT));
        default: shifted = data;
      endcase
    end
  end

`ifdef BARRELSHIFTER_FLAGS_EN
  // Signed overflow: any bit pushed out, or the new MSB, disagrees with the original sign.
  always_comb begin
    vf_next = vf_acc;
    if (en && (op == SLL)) begin
      vf_next = vf_acc
              | (|(data[D_SIZE-1 -: SHIFT] ^ {SHIFT{sign}}))
              | (shifted[D_SIZE-1] ^ sign);
    end
  end
`endif

endmodule

// File: rtl/barrelshifter_pipe.sv
// Pipelined barrel shifter: S_W registered stages, stage k moves by 2^k, global stall.
// Define BARRELSHIFTER_FLAGS_EN to build the zero/overflow flag logic; otherwise flags are tied to 0.
module barrelshifter_pipe
  import barrelshifter_pkg::*;
#(
  parameter  int D_SIZE = 32,
  localparam int S_W    = $clog2(D_SIZE)
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [D_SIZE-1:0] x_in,
  input  logic [S_W-1:0]    s_in,
  input  op_t               op_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [D_SIZE-1:0] y_out,
  output logic              zf_out,
  output logic              vf_out
);

  // Stage inputs: index 0 comes from the ports, index k from pipeline register k-1.
  op_t               st_op    [S_W];
  logic [S_W-1:0]    st_s     [S_W];
  logic [D_SIZE-1:0] st_data  [S_W];
  logic              st_valid [S_W];
  logic [D_SIZE-1:0] shifted  [S_W];

  logic [D_SIZE-1:0] data_reg  [S_W];
  logic              valid_reg [S_W];
  op_t               op_reg    [S_W-1];
  logic [S_W-1:0]    s_reg     [S_W-1];

  logic advance;

  assign advance   = !valid_reg[S_W-1] || ready_in;
  assign ready_out = advance;

  assign st_op[0]    = op_in;
  assign st_s[0]     = s_in;
  assign st_data[0]  = x_in;
  assign st_valid[0] = valid_in;

`ifdef BARRELSHIFTER_FLAGS_EN
  logic st_sign  [S_W];
  logic st_vf    [S_W];
  logic vf_next  [S_W];
  logic vf_reg   [S_W];
  logic sign_reg [S_W-1];

  assign st_sign[0] = x_in[D_SIZE-1];
  assign st_vf[0]   = 1'b0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < S_W; gi++) begin : g_stage
      barrelshifter_stage #(
        .D_SIZE (D_SIZE),
        .SHIFT  (1 << gi)
      ) u_stage (
        .op      (st_op[gi]),
        .en      (st_s[gi][gi]),
        .data    (st_data[gi]),
`ifdef BARRELSHIFTER_FLAGS_EN
        .sign    (st_sign[gi]),
        .vf_acc  (st_vf[gi]),
        .vf_next (vf_next[gi]),
`endif
        .shifted (shifted[gi])
      );

      // Bubbles advance like real operands; only the valid bit marks them.
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          data_reg[gi]  <= '0;
          valid_reg[gi] <= 1'b0;
        end else if (advance) begin
          data_reg[gi]  <= shifted[gi];
          valid_reg[gi] <= st_valid[gi];
        end
      end

`ifdef BARRELSHIFTER_FLAGS_EN
      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          vf_reg[gi] <= 1'b0;
        end else if (advance) begin
          vf_reg[gi] <= vf_next[gi];
        end
      end
`endif

      // Control fields are only needed up to the last stage's input.
      if (gi < S_W - 1) begin : g_fwd
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) begin
            op_reg[gi] <= SLL;
            s_reg[gi]  <= '0;
          end else if (advance) begin
            op_reg[gi] <= st_op[gi];
            s_reg[gi]  <= st_s[gi];
          end
        end

        assign st_op[gi+1]    = op_reg[gi];
        assign st_s[gi+1]     = s_reg[gi];
        assign st_data[gi+1]  = data_reg[gi];
        assign st_valid[gi+1] = valid_reg[gi];

`ifdef BARRELSHIFTER_FLAGS_EN
        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) begin
            sign_reg[gi] <= 1'b0;
          end else if (advance) begin
            sign_reg[gi] <= st_sign[gi];
          end
        end

        assign st_sign[gi+1] = sign_reg[gi];
        assign st_vf[gi+1]   = vf_reg[gi];
`endif
      end
    end
  endgenerate

  assign valid_out = valid_reg[S_W-1];
  assign y_out     = data_reg[S_W-1];

`ifdef BARRELSHIFTER_FLAGS_EN
  assign zf_out = valid_out && (y_out == '0);
  assign vf_out = valid_out && vf_reg[S_W-1];
`else
  assign zf_out = 1'b0;
  assign vf_out = 1'b0;
`endif

endmodule

// File: tb/tb_barrelshifter_pipe.sv
// Scoreboard bench for barrelshifter_pipe at D_SIZE=8 (three pipeline stages).
// Expected flags follow BARRELSHIFTER_FLAGS_EN: modelled when defined, zero otherwise.
module tb_barrelshifter_pipe;
  import barrelshifter_pkg::*;

  localparam int D   = 8;
  localparam int LAT = 3;

  logic         clk_in   = 1'b0;
  logic         rst_n_in = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_in = 1'b1;
  logic [D-1:0] x_in     = '0;
  logic [2:0]   s_in     = '0;
  op_t          op_in    = SLL;
  logic         ready_out;
  logic         valid_out;
  logic [D-1:0] y_out;
  logic         zf_out;
  logic         vf_out;

  barrelshifter_pipe #(.D_SIZE(D)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .x_in      (x_in),
    .s_in      (s_in),
    .op_in     (op_in),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .y_out     (y_out),
    .zf_out    (zf_out),
    .vf_out    (vf_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [D-1:0] y;
    logic         zf;
    logic         vf;
    int           cyc;
    bit           chk_lat;
    string        tag;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   lat_mode = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model written bit-by-bit, independent of the stage decomposition.
  function automatic logic [D-1:0] model_y(input logic [2:0] op, input logic [D-1:0] x, input int s);
    logic [D-1:0] y;
    y = x;
    for (int i = 0; i < D; i++) begin
      case (op)
        3'b000: y[i] = (i - s >= 0) ? x[i-s] : 1'b0;
        3'b001: y[i] = (i + s < D) ? x[i+s] : 1'b0;
        3'b010: y[i] = (i + s < D) ? x[i+s] : x[D-1];
        3'b011: y[i] = x[(i - s + D) % D];
        3'b100: y[i] = x[(i + s) % D];
        default: y[i] = x[i];
      endcase
    end
    return y;
  endfunction

  // SLL overflows unless the top s+1 bits of x all equal its sign bit.
  function automatic logic model_vf(input logic [2:0] op, input logic [D-1:0] x, input int s);
    logic v;
    v = 1'b0;
    if (op == 3'b000)
      for (int i = D - 1 - s; i < D; i++)
        if (x[i] != x[D-1]) v = 1'b1;
    return v;
  endfunction

  // Called just after a rising edge; returns just after the edge that accepted the operand.
  task automatic send(input string tag, input logic [2:0] op, input logic [D-1:0] x, input logic [2:0] s);
    bit   acc;
    int   n;
    int   c;
    exp_t e;
    valid_in = 1'b1;
    op_in    = op_t'(op);
    x_in     = x;
    s_in     = s;
    acc      = 1'b0;
    n        = 0;
    c        = 0;
    while (!acc && n < 50) begin
      @(negedge clk_in);
      acc = ready_out;
      c   = cyc;
      @(posedge clk_in);
      #1;
      n++;
    end
    valid_in = 1'b0;
    if (!acc) begin
      check({tag, "_accept_timeout"}, 32'd0, 32'd1);
    end else begin
      e.y = model_y(op, x, int'(s));
`ifdef BARRELSHIFTER_FLAGS_EN
      e.zf = (e.y == '0);
      e.vf = model_vf(op, x, int'(s));
`else
      e.zf = 1'b0;
      e.vf = 1'b0;
`endif
      e.cyc     = c;
      e.chk_lat = lat_mode;
      e.tag     = tag;
      q.push_back(e);
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (q.size() > 0 && n < max_cycles) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    check("drain_queue_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // Scoreboard: a transfer out happens at the next edge when valid_out && ready_in.
  always @(negedge clk_in) begin
    exp_t e;
    if (rst_n_in && valid_out && ready_in) begin
      if (q.size() == 0) begin
        check("spurious_output", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        $display("OUT %s y=0x%02h zf=%0b vf=%0b exp_y=0x%02h exp_zf=%0b exp_vf=%0b lat=%0d",
                 e.tag, y_out, zf_out, vf_out, e.y, e.zf, e.vf, cyc - e.cyc);
        check({e.tag, "_y"}, 32'(y_out), 32'(e.y));
        check({e.tag, "_zf"}, 32'(zf_out), 32'(e.zf));
        check({e.tag, "_vf"}, 32'(vf_out), 32'(e.vf));
        if (e.chk_lat) check({e.tag, "_latency"}, 32'(cyc - e.cyc), 32'(LAT));
      end
    end else if ($isunknown({zf_out, vf_out, valid_out})) begin
      check("outputs_x", 32'd1, 32'd0);
    end
  end

  typedef struct {
    string      tag;
    logic [2:0] op;
    logic [7:0] x;
    logic [2:0] s;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [D-1:0] y_hold;
    int           n;

    #1;
    check("reset_valid_out", 32'(valid_out), 32'd0);
    check("reset_y_out", 32'(y_out), 32'd0);
    check("reset_zf_out", 32'(zf_out), 32'd0);
    check("reset_vf_out", 32'(vf_out), 32'd0);
    check("reset_ready_out", 32'(ready_out), 32'd1);
    idle(2);
    rst_n_in = 1'b1;

    // Isolated operand to measure first-transaction latency.
    send("sll_03_s2", 3'b000, 8'h03, 3'd2);
    drain(20);

    vecs = '{
      '{"srl_80_s7", 3'b001, 8'h80, 3'd7},
      '{"sra_80_s7", 3'b010, 8'h80, 3'd7},
      '{"ror_01_s1", 3'b100, 8'h01, 3'd1},
      '{"rol_81_s1", 3'b011, 8'h81, 3'd1},
      '{"sll_40_s1", 3'b000, 8'h40, 3'd1},
      '{"srl_01_s1", 3'b001, 8'h01, 3'd1},
      '{"op5_5a_s3", 3'b101, 8'h5A, 3'd3},
      '{"sra_7f_s0", 3'b010, 8'h7F, 3'd0},
      '{"sll_c1_s1", 3'b000, 8'hC1, 3'd1},
      '{"sll_ff_s7", 3'b000, 8'hFF, 3'd7},
      '{"ror_96_s5", 3'b100, 8'h96, 3'd5},
      '{"op7_00_s4", 3'b111, 8'h00, 3'd4}
    };
    foreach (vecs[i]) send(vecs[i].tag, vecs[i].op, vecs[i].x, vecs[i].s);
    drain(30);

    // Back-to-back burst with a two-cycle downstream stall once results appear.
    lat_mode = 1'b0;
    fork
      begin
        send("stall_a", 3'b000, 8'h11, 3'd1);
        send("stall_b", 3'b001, 8'h22, 3'd2);
        send("stall_c", 3'b011, 8'h33, 3'd3);
        send("stall_d", 3'b100, 8'h44, 3'd4);
      end
      begin
        n = 0;
        while (!valid_out && n < 20) begin
          @(negedge clk_in);
          n++;
        end
        check("stall_valid_seen", 32'(valid_out), 32'd1);
        @(posedge clk_in);
        #1;
        ready_in = 1'b0;
        @(negedge clk_in);
        y_hold = y_out;
        check("stall_ready_out_0", 32'(ready_out), 32'd0);
        @(negedge clk_in);
        check("stall_ready_out_1", 32'(ready_out), 32'd0);
        check("stall_y_held", 32'(y_out), 32'(y_hold));
        @(posedge clk_in);
        #1;
        ready_in = 1'b1;
      end
    join
    drain(30);

    // Random operands against random downstream backpressure.
    fork
      begin
        for (int i = 0; i < 24; i++)
          send($sformatf("rnd%0d", i), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
               3'($urandom_range(0, 7)));
      end
      begin
        for (int i = 0; i < 60; i++) begin
          @(posedge clk_in);
          #1;
          ready_in = 1'($urandom_range(0, 1));
        end
        ready_in = 1'b1;
      end
    join
    drain(60);

    // Reset with three operands in flight: everything in the pipe is discarded.
    send("rst_a", 3'b000, 8'h01, 3'd1);
    send("rst_b", 3'b000, 8'h02, 3'd1);
    send("rst_c", 3'b000, 8'h04, 3'd1);
    rst_n_in = 1'b0;
    #1;
    check("async_rst_valid_out", 32'(valid_out), 32'd0);
    check("async_rst_y_out", 32'(y_out), 32'd0);
    check("async_rst_ready_out", 32'(ready_out), 32'd1);
    q.delete();
    idle(2);
    rst_n_in = 1'b1;
    idle(6);
    lat_mode = 1'b1;
    send("post_rst_srl", 3'b001, 8'hF0, 3'd4);
    drain(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
